// File: rtl/amo_unit.sv
// A-extension executor: LR/SC with a single-word, aging reservation and
// AMO read-modify-write against the word-wide data memory port.
module amo_unit #(
    parameter int RESV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_sel,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_cmd_valid,
    input  logic        mem_cmd_ready,
    output logic        mem_cmd_wen,
    output logic [31:0] mem_cmd_addr,
    output logic [31:0] mem_cmd_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    input  logic        resv_clear,
    input  logic        snoop_wvalid,
    input  logic [31:0] snoop_waddr
);
    localparam logic [3:0] ASEL_X    = 4'd0;
    localparam logic [3:0] ASEL_LR   = 4'd1;
    localparam logic [3:0] ASEL_SC   = 4'd2;
    localparam logic [3:0] ASEL_SWAP = 4'd3;
    localparam logic [3:0] ASEL_ADD  = 4'd4;
    localparam logic [3:0] ASEL_XOR  = 4'd5;
    localparam logic [3:0] ASEL_AND  = 4'd6;
    localparam logic [3:0] ASEL_OR   = 4'd7;
    localparam logic [3:0] ASEL_MAX  = 4'd8;
    localparam logic [3:0] ASEL_MIN  = 4'd9;
    localparam logic [9:0] TMO       = RESV_TIMEOUT[9:0];

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_WAIT, S_WR, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q;
    logic [29:0] addr_q;
    logic [31:0] rs2_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        resv_valid;
    logic [29:0] resv_addr;
    logic [9:0]  resv_age;
    logic [31:0] amo_result;

    logic [29:0] req_word;
    logic        accept, req_bad, sc_hit, rd_capture;
    logic        resv_set, set_kill, resv_kill, amo_wr_hit;
    logic        unused_snoop_lsb;

    assign req_word   = req_addr[31:2];
    assign accept     = req_valid && (state_q == S_IDLE);
    assign req_bad    = (req_addr[1:0] != 2'b00) || (req_sel == ASEL_X) || (req_sel > ASEL_MIN);
    // A store landing on the same word in the accept cycle already voids the SC.
    assign sc_hit     = resv_valid && (resv_addr == req_word) && !resv_clear &&
                        !(snoop_wvalid && (snoop_waddr[31:2] == req_word));
    assign rd_capture = (state_q == S_RD_WAIT) && mem_resp_valid;
    assign unused_snoop_lsb = ^snoop_waddr[1:0];

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_bad)                 state_d = S_RESP;
                    else if (req_sel == ASEL_SC) state_d = sc_hit ? S_WR : S_RESP;
                    else                         state_d = S_RD;
                end
            end
            S_RD:      if (mem_cmd_ready) state_d = S_RD_WAIT;
            S_RD_WAIT: if (mem_resp_valid) state_d = (op_q == ASEL_LR) ? S_RESP : S_WR;
            S_WR:      if (mem_cmd_ready) state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        amo_result = rs2_q;
        case (op_q)
            ASEL_SWAP: amo_result = rs2_q;
            ASEL_ADD:  amo_result = mem_resp_rdata + rs2_q;
            ASEL_XOR:  amo_result = mem_resp_rdata ^ rs2_q;
            ASEL_AND:  amo_result = mem_resp_rdata & rs2_q;
            ASEL_OR:   amo_result = mem_resp_rdata | rs2_q;
            ASEL_MAX:  amo_result = ($signed(rs2_q) > $signed(mem_resp_rdata)) ? rs2_q : mem_resp_rdata;
            ASEL_MIN:  amo_result = ($signed(rs2_q) < $signed(mem_resp_rdata)) ? rs2_q : mem_resp_rdata;
            default:   amo_result = rs2_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= ASEL_X;
            addr_q  <= '0;
            rs2_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= req_sel;
                addr_q  <= req_word;
                rs2_q   <= req_wdata;
                wdata_q <= req_wdata;
                err_q   <= req_bad;
                rdata_q <= (!req_bad && req_sel == ASEL_SC && !sc_hit) ? 32'd1 : 32'd0;
            end
            if (rd_capture) begin
                rdata_q <= mem_resp_rdata;
                wdata_q <= amo_result;
            end
        end
    end

    // Reservation: age counts cycles since set; valid while age <= RESV_TIMEOUT.
    assign resv_set   = rd_capture && (op_q == ASEL_LR);
    assign set_kill   = resv_clear || (snoop_wvalid && (snoop_waddr[31:2] == addr_q));
    assign amo_wr_hit = (state_q == S_WR) && mem_cmd_ready && (op_q != ASEL_SC) && (addr_q == resv_addr);
    assign resv_kill  = resv_clear || (accept && req_sel == ASEL_SC) || amo_wr_hit ||
                        (snoop_wvalid && (snoop_waddr[31:2] == resv_addr)) ||
                        (resv_valid && resv_age >= TMO);

    always_ff @(posedge clk) begin
        if (reset) begin
            resv_valid <= 1'b0;
            resv_addr  <= '0;
            resv_age   <= '0;
        end else if (resv_set && !set_kill) begin
            resv_valid <= 1'b1;
            resv_addr  <= addr_q;
            resv_age   <= 10'd1;
        end else if (resv_kill || resv_set) begin
            resv_valid <= 1'b0;
            resv_age   <= '0;
        end else if (resv_valid) begin
            resv_age   <= resv_age + 10'd1;
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign resp_valid    = (state_q == S_RESP);
    assign resp_rdata    = (state_q == S_RESP) ? rdata_q : 32'd0;
    assign resp_error    = (state_q == S_RESP) && err_q;
    assign mem_cmd_valid = (state_q == S_RD) || (state_q == S_WR);
    assign mem_cmd_wen   = (state_q == S_WR);
    assign mem_cmd_addr  = {addr_q, 2'b00};
    assign mem_cmd_wdata = wdata_q;

endmodule

// File: tb/tb_amo_unit.sv
// Directed bench for amo_unit: zero-wait/stalling memory responder plus
// per-scenario tasks with hand-computed expectations.
module tb_amo_unit;
    localparam logic [3:0] ASEL_X    = 4'd0;
    localparam logic [3:0] ASEL_LR   = 4'd1;
    localparam logic [3:0] ASEL_SC   = 4'd2;
    localparam logic [3:0] ASEL_SWAP = 4'd3;
    localparam logic [3:0] ASEL_ADD  = 4'd4;
    localparam logic [3:0] ASEL_XOR  = 4'd5;
    localparam logic [3:0] ASEL_AND  = 4'd6;
    localparam logic [3:0] ASEL_OR   = 4'd7;
    localparam logic [3:0] ASEL_MAX  = 4'd8;
    localparam logic [3:0] ASEL_MIN  = 4'd9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_sel = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic        mem_cmd_wen;
    logic [31:0] mem_cmd_addr;
    logic [31:0] mem_cmd_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = '0;
    logic        resv_clear = 1'b0;
    logic        snoop_wvalid = 1'b0;
    logic [31:0] snoop_waddr = '0;

    int errors = 0;
    int checks = 0;

    amo_unit #(.RESV_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_wen(mem_cmd_wen),
        .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .resv_clear(resv_clear), .snoop_wvalid(snoop_wvalid), .snoop_waddr(snoop_waddr)
    );

    always #5 clk = ~clk;

    // Memory responder: optional command stall and read latency.
    logic [31:0] mem [logic [31:0]];
    int          mem_lat = 0;
    int          stall_cfg = 0;
    int          stall_ctr = 0;
    logic        rd_pend = 1'b0;
    int          rd_cnt = 0;
    logic        pre_we = 1'b0;
    logic [31:0] pre_addr = '0, pre_data = '0;
    int          wr_count = 0, rd_count = 0, cmd_cycles = 0, stable_err = 0;
    logic [31:0] last_waddr = '0, last_wdata = '0;
    logic        stall_seen = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    logic        p_wen = 1'b0;

    assign mem_cmd_ready = (stall_ctr == 0);

    always @(posedge clk) begin
        logic [31:0] d;
        mem_resp_valid <= 1'b0;
        if (pre_we) mem[pre_addr] = pre_data;
        if (rd_pend) begin
            if (rd_cnt == 0) begin mem_resp_valid <= 1'b1; rd_pend <= 1'b0; end
            else rd_cnt <= rd_cnt - 1;
        end
        if (mem_cmd_valid) cmd_cycles++;
        if (stall_seen && (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== p_addr ||
                           mem_cmd_wen !== p_wen || mem_cmd_wdata !== p_wdata))
            stable_err++;
        stall_seen <= mem_cmd_valid && !mem_cmd_ready;
        p_addr <= mem_cmd_addr; p_wen <= mem_cmd_wen; p_wdata <= mem_cmd_wdata;
        if (!mem_cmd_valid) stall_ctr <= stall_cfg;
        else if (stall_ctr != 0) stall_ctr <= stall_ctr - 1;
        else begin
            stall_ctr <= stall_cfg;
            if (mem_cmd_wen) begin
                mem[mem_cmd_addr] = mem_cmd_wdata;
                wr_count++;
                last_waddr = mem_cmd_addr;
                last_wdata = mem_cmd_wdata;
            end else begin
                rd_count++;
                d = mem.exists(mem_cmd_addr) ? mem[mem_cmd_addr] : 32'd0;
                mem_resp_rdata <= d;
                if (mem_lat == 0) mem_resp_valid <= 1'b1;
                else begin rd_pend <= 1'b1; rd_cnt <= mem_lat - 1; end
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        tick;
        pre_we = 1'b0;
    endtask

    // Issue one op; lat = cycles from accept to resp_valid (-1 on timeout).
    // Returns in the cycle after the response.
    task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] wd,
                          input logic clr, output int lat, output logic [31:0] rd, output logic err);
        lat = -1; rd = '0; err = 1'b0;
        for (int g = 0; g < 20 && !req_ready; g++) tick;
        req_valid = 1'b1; req_sel = sel; req_addr = a; req_wdata = wd; resv_clear = clr;
        tick;
        req_valid = 1'b0; resv_clear = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (resp_valid) begin lat = c; rd = resp_rdata; err = resp_error; break; end
            tick;
        end
        if (lat > 0) tick;
    endtask

    task automatic test_reset;
        reset = 1'b1; tick; tick;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_error !== 1'b0 || resp_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_resp: ready=%b valid=%b err=%b rdata=%h want 1 0 0 0", req_ready, resp_valid, resp_error, resp_rdata); end
        checks++; if (mem_cmd_valid !== 1'b0 || mem_cmd_wen !== 1'b0 || mem_cmd_addr !== 32'd0 || mem_cmd_wdata !== 32'd0) begin
            errors++; $display("FAIL reset_cmd: valid=%b wen=%b addr=%h wdata=%h want all 0", mem_cmd_valid, mem_cmd_wen, mem_cmd_addr, mem_cmd_wdata); end
        reset = 1'b0; tick;
    endtask

    task automatic test_amo_add;
        int lat; logic [31:0] rd; logic err; int w0;
        preload(32'h100, 32'h10);
        w0 = wr_count;
        run_op(ASEL_ADD, 32'h100, 32'd5, 1'b0, lat, rd, err);
        checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d want 4", lat); end
        checks++; if (rd !== 32'h10 || err !== 1'b0) begin errors++; $display("FAIL add_rdata: got %h err=%b want 00000010 0", rd, err); end
        checks++; if (wr_count - w0 !== 1 || last_waddr !== 32'h100 || last_wdata !== 32'h15) begin
            errors++; $display("FAIL add_write: n=%0d addr=%h data=%h want 1 00000100 00000015", wr_count - w0, last_waddr, last_wdata); end
        preload(32'h104, 32'hFFFF_FFFF);
        run_op(ASEL_ADD, 32'h104, 32'd2, 1'b0, lat, rd, err);
        checks++; if (last_wdata !== 32'd1 || rd !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL add_wrap: wdata=%h rdata=%h want 00000001 ffffffff", last_wdata, rd); end
    endtask

    task automatic test_lr_sc;
        int lat; logic [31:0] rd; logic err; int w0;
        preload(32'h200, 32'hAB);
        run_op(ASEL_LR, 32'h200, 32'd0, 1'b0, lat, rd, err);
        checks++; if (lat !== 3 || rd !== 32'hAB) begin errors++; $display("FAIL lr: lat=%0d rdata=%h want 3 000000ab", lat, rd); end
        w0 = wr_count;
        run_op(ASEL_SC, 32'h200, 32'd7, 1'b0, lat, rd, err);
        checks++; if (lat !== 2 || rd !== 32'd0) begin errors++; $display("FAIL sc_hit: lat=%0d rdata=%h want 2 0", lat, rd); end
        checks++; if (wr_count - w0 !== 1 || last_waddr !== 32'h200 || last_wdata !== 32'd7) begin
            errors++; $display("FAIL sc_hit_write: n=%0d addr=%h data=%h want 1 00000200 00000007", wr_count - w0, last_waddr, last_wdata); end
        w0 = wr_count;
        run_op(ASEL_SC, 32'h200, 32'd8, 1'b0, lat, rd, err);
        checks++; if (lat !== 1 || rd !== 32'd1 || wr_count !== w0) begin
            errors++; $display("FAIL sc_second: lat=%0d rdata=%h writes=%0d want 1 1 0", lat, rd, wr_count - w0); end
    endtask

    task automatic test_resv_kill;
        int lat; logic [31:0] rd; logic err; int w0;
        preload(32'h200, 32'hAB);
        run_op(ASEL_LR, 32'h200, 32'd0, 1'b0, lat, rd, err);
        snoop_wvalid = 1'b1; snoop_waddr = 32'h202;
        tick;
        snoop_wvalid = 1'b0;
        w0 = wr_count;
        run_op(ASEL_SC, 32'h200, 32'd9, 1'b0, lat, rd, err);
        checks++; if (rd !== 32'd1 || wr_count !== w0) begin errors++; $display("FAIL sc_after_snoop: rdata=%h writes=%0d want 1 0", rd, wr_count - w0); end
        run_op(ASEL_LR, 32'h200, 32'd0, 1'b0, lat, rd, err);
        w0 = wr_count;
        run_op(ASEL_SC, 32'h200, 32'd9, 1'b1, lat, rd, err);
        checks++; if (rd !== 32'd1 || wr_count !== w0) begin errors++; $display("FAIL sc_with_clear: rdata=%h writes=%0d want 1 0", rd, wr_count - w0); end
    endtask

    // RESV_TIMEOUT=4: LR resp at cycle 3, reservation valid through cycle 6.
    task automatic test_timeout;
        int lat; logic [31:0] rd; logic err;
        int gap [3] = '{2, 3, 4};
        logic [31:0] want [3] = '{32'd0, 32'd1, 32'd1};
        for (int k = 0; k < 3; k++) begin
            run_op(ASEL_LR, 32'h200, 32'd0, 1'b0, lat, rd, err);
            for (int t = 0; t < gap[k]; t++) tick;
            run_op(ASEL_SC, 32'h200, 32'd3, 1'b0, lat, rd, err);
            checks++; if (rd !== want[k]) begin errors++; $display("FAIL sc_timeout_gap%0d: rdata=%h want %h", gap[k] + 1, rd, want[k]); end
        end
    endtask

    task automatic test_logic_ops;
        int lat; logic [31:0] rd; logic err;
        logic [3:0]  sel [6] = '{ASEL_SWAP, ASEL_XOR, ASEL_AND, ASEL_OR, ASEL_MAX, ASEL_MIN};
        logic [31:0] old [6] = '{32'hF0F0_00FF, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] rs2 [6] = '{32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'd1, 32'd1};
        logic [31:0] exp [6] = '{32'h0FF0_0F0F, 32'hFF00_0FF0, 32'h00F0_000F, 32'hFFF0_0FFF, 32'd1, 32'hFFFF_FFFF};
        for (int k = 0; k < 6; k++) begin
            preload(32'h300, old[k]);
            run_op(sel[k], 32'h300, rs2[k], 1'b0, lat, rd, err);
            checks++; if (last_wdata !== exp[k] || rd !== old[k] || lat !== 4) begin
                errors++; $display("FAIL amo_op%0d: wdata=%h rdata=%h lat=%0d want %h %h 4", sel[k], last_wdata, rd, lat, exp[k], old[k]); end
        end
    endtask

    task automatic test_error;
        int lat; logic [31:0] rd; logic err; int c0;
        c0 = cmd_cycles;
        run_op(ASEL_SWAP, 32'h103, 32'd1, 1'b0, lat, rd, err);
        checks++; if (lat !== 1 || err !== 1'b1 || rd !== 32'd0 || cmd_cycles !== c0) begin
            errors++; $display("FAIL err_misaligned: lat=%0d err=%b rdata=%h cmds=%0d want 1 1 0 0", lat, err, rd, cmd_cycles - c0); end
        run_op(ASEL_X, 32'h100, 32'd1, 1'b0, lat, rd, err);
        checks++; if (lat !== 1 || err !== 1'b1 || rd !== 32'd0 || cmd_cycles !== c0) begin
            errors++; $display("FAIL err_asel_x: lat=%0d err=%b rdata=%h cmds=%0d want 1 1 0 0", lat, err, rd, cmd_cycles - c0); end
    endtask

    task automatic test_backpressure;
        int lat; logic [31:0] rd; logic err; int s0;
        preload(32'h400, 32'd1);
        stall_cfg = 3;
        tick;
        s0 = stable_err;
        run_op(ASEL_ADD, 32'h400, 32'd2, 1'b0, lat, rd, err);
        stall_cfg = 0;
        checks++; if (lat !== 10) begin errors++; $display("FAIL bp_latency: got %0d want 10", lat); end
        checks++; if (stable_err !== s0) begin errors++; $display("FAIL bp_stable: unstable cycles=%0d want 0", stable_err - s0); end
        checks++; if (last_wdata !== 32'd3 || rd !== 32'd1) begin errors++; $display("FAIL bp_data: wdata=%h rdata=%h want 3 1", last_wdata, rd); end
    endtask

    task automatic test_reset_midop;
        int c0, w0; logic seen;
        mem_lat = 2;
        preload(32'h500, 32'd9);
        w0 = wr_count;
        req_valid = 1'b1; req_sel = ASEL_ADD; req_addr = 32'h500; req_wdata = 32'd1;
        tick;
        req_valid = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_midop_idle: ready=%b resp_valid=%b want 1 0", req_ready, resp_valid); end
        c0 = cmd_cycles; seen = 1'b0;
        for (int t = 0; t < 6; t++) begin tick; if (resp_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0 || cmd_cycles !== c0 || wr_count !== w0) begin
            errors++; $display("FAIL reset_midop_quiet: resp=%b cmds=%0d writes=%0d want 0 0 0", seen, cmd_cycles - c0, wr_count - w0); end
        mem_lat = 0;
    endtask

    initial begin
        test_reset;
        test_amo_add;
        test_lr_sc;
        test_resv_kill;
        test_timeout;
        test_logic_ops;
        test_error;
        test_backpressure;
        test_reset_midop;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
